// File: rtl/spi_engine.sv
// rtl/spi_engine.sv - word-level SPI master shifter; LSB-first option enabled by macro SPI_LSBFIRST_EN
module spi_engine #(
    parameter int WIDTH = 8,
    parameter int NSS   = 2,
    parameter int DIVW  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] txd_i,
    input  logic [NSS-1:0]   ssmask_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic [DIVW-1:0]  div_i,
    input  logic             hold_i,
`ifdef SPI_LSBFIRST_EN
    input  logic             lsbf_i,
`endif
    input  logic [NSS-1:0]   miso_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] rxd_o,
    output logic             sck_o,
    output logic             mosi_o,
    output logic [NSS-1:0]   nss_o
);

    localparam int ECW = $clog2(2*WIDTH+1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2*WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_TAIL, S_FIN} state_t;

    state_t           state_q;
    logic [DIVW-1:0]  cnt_q, div_q;
    logic [ECW-1:0]   ecnt_q;
    logic [WIDTH-1:0] tx_q, rx_q, rxd_q;
    logic [NSS-1:0]   mask_q, nss_q;
    logic             cpol_q, cpha_q, hold_q, lsbf_q;
    logic             busy_q, done_q, sck_q, mosi_q;

    logic             lsbf_in;
    logic             tick_d, sample_d, miso_bit_d, tx_bit_d, in_bit_d;
    logic [ECW-1:0]   edge_num_d;
    logic [WIDTH-1:0] tx_next_d, in_next_d, rx_next_d;

`ifdef SPI_LSBFIRST_EN
    assign lsbf_in = lsbf_i;
`else
    assign lsbf_in = 1'b0;
`endif

    // Edge classification and shift-register next values; odd edges are leading edges
    always_comb begin
        tick_d     = (cnt_q == '0);
        edge_num_d = ecnt_q + ECW'(1);
        sample_d   = edge_num_d[0] ^ cpha_q;
        miso_bit_d = |(miso_i & mask_q);
        tx_bit_d   = lsbf_q ? tx_q[0] : tx_q[WIDTH-1];
        tx_next_d  = lsbf_q ? (tx_q >> 1) : (tx_q << 1);
        in_bit_d   = lsbf_in ? txd_i[0] : txd_i[WIDTH-1];
        in_next_d  = lsbf_in ? (txd_i >> 1) : (txd_i << 1);
        rx_next_d  = lsbf_q ? {miso_bit_d, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], miso_bit_d};
    end

    // Transfer sequencer: IDLE -> SETUP -> SHIFT -> TAIL -> FIN, all outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            ecnt_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxd_q   <= '0;
            mask_q  <= '0;
            nss_q   <= '1;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            hold_q  <= 1'b0;
            lsbf_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                nss_q   <= '1;
                sck_q   <= cpol_q;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            state_q <= S_SETUP;
                            busy_q  <= 1'b1;
                            mask_q  <= ssmask_i;
                            nss_q   <= ~ssmask_i;
                            cpol_q  <= cpol_i;
                            cpha_q  <= cpha_i;
                            hold_q  <= hold_i;
                            lsbf_q  <= lsbf_in;
                            div_q   <= div_i;
                            cnt_q   <= div_i;
                            sck_q   <= cpol_i;
                            ecnt_q  <= '0;
                            rx_q    <= '0;
                            if (cpha_i) begin
                                tx_q <= txd_i;
                            end else begin
                                mosi_q <= in_bit_d;
                                tx_q   <= in_next_d;
                            end
                        end
                    end
                    S_SETUP, S_SHIFT: begin
                        if (!tick_d) begin
                            cnt_q <= cnt_q - DIVW'(1);
                        end else begin
                            cnt_q <= div_q;
                            if (state_q == S_SHIFT && ecnt_q == LAST_EDGE) begin
                                state_q <= S_TAIL;
                                sck_q   <= cpol_q;
                            end else begin
                                state_q <= S_SHIFT;
                                sck_q   <= ~sck_q;
                                ecnt_q  <= edge_num_d;
                                if (sample_d) begin
                                    rx_q <= rx_next_d;
                                end else begin
                                    mosi_q <= tx_bit_d;
                                    tx_q   <= tx_next_d;
                                end
                            end
                        end
                    end
                    S_TAIL: begin
                        if (!tick_d) begin
                            cnt_q <= cnt_q - DIVW'(1);
                        end else begin
                            cnt_q   <= div_q;
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            rxd_q   <= rx_q;
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (!hold_q) begin
                            nss_q <= '1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign rxd_o  = rxd_q;
    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;
    assign nss_o  = nss_q;

endmodule

// File: tb/tb_spi_engine.sv
// tb/tb_spi_engine.sv - self-checking bench for spi_engine with RXD scoreboard
`timescale 1ns/1ps
module tb_spi_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, cpol = 1'b0, cpha = 1'b0, hold = 1'b0, lsbf = 1'b0;
    logic [7:0] txd = '0;
    logic [1:0] mask = '0, miso = '0;
    logic [3:0] div = '0;
    logic       busy, done, sck, mosi;
    logic [7:0] rxd;
    logic [1:0] nss;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rxd = '0;

    // observations collected by xfer
    logic [7:0] o_mosi, o_rxd;
    logic [1:0] o_nss1, o_nss_or;
    logic       o_busy1, o_first_bit;
    int         o_rises, o_done, o_first, o_hp;

    always #5 clk = ~clk;

    spi_engine #(.WIDTH(8), .NSS(2), .DIVW(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .txd_i(txd), .ssmask_i(mask), .cpol_i(cpol), .cpha_i(cpha),
        .div_i(div), .hold_i(hold),
`ifdef SPI_LSBFIRST_EN
        .lsbf_i(lsbf),
`endif
        .miso_i(miso), .busy_o(busy), .done_o(done), .rxd_o(rxd),
        .sck_o(sck), .mosi_o(mosi), .nss_o(nss)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // patterns are time-ordered: bit 7 is the first bit on the wire
    function automatic logic [7:0] model_rx(input logic [7:0] p0, input logic [7:0] p1,
                                            input logic [1:0] m, input logic lb);
        logic [7:0] r;
        r = (p0 & {8{m[0]}}) | (p1 & {8{m[1]}});
        return lb ? rev8(r) : r;
    endfunction

    // Called at a negedge; drives one transfer, acts as the SPI slave, returns at DONE or after an abort
    task automatic xfer(input logic [7:0] t, input logic [1:0] m, input logic pl, input logic ph,
                        input logic [3:0] d, input logic h, input logic [7:0] p0, input logic [7:0] p1,
                        input logic lb, input int abort_at, input logic poke);
        int cyc, edges, idx, last_edge;
        logic prev_sck;
        txd = t; mask = m; cpol = pl; cpha = ph; div = d; hold = h; lsbf = lb;
        idx = 0;
        miso = {p1[7], p0[7]};
        start = 1'b1;
        cyc = 0; edges = 0; last_edge = 0; prev_sck = pl;
        o_mosi = '0; o_rxd = 'x; o_rises = 0; o_done = -1; o_first = -1; o_hp = -1;
        o_nss_or = '0; o_first_bit = 1'b0; o_busy1 = 1'b0; o_nss1 = 'x;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                o_busy1 = busy;
                o_nss1 = nss;
                txd = ~t; mask = ~m; cpol = ~pl; cpha = ~ph; div = d + 4'd3; hold = ~h; lsbf = ~lb;
            end
            if (poke && cyc == 5) start = 1'b1;
            if (poke && cyc == 6) start = 1'b0;
            o_nss_or = o_nss_or | nss;
            if (sck !== prev_sck) begin
                edges++;
                if (sck === 1'b1) o_rises++;
                if (edges == 1) o_first = cyc;
                if (edges == 2) o_hp = cyc - last_edge;
                last_edge = cyc;
                if (((edges % 2) == 1) != ph) begin
                    o_mosi = {o_mosi[6:0], mosi};
                    if (idx == 0) o_first_bit = mosi;
                    idx++;
                    miso = (idx < 8) ? {p1[7-idx], p0[7-idx]} : 2'b00;
                end
            end
            prev_sck = sck;
            if (abort_at > 0 && edges == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                return;
            end
            if (done === 1'b1) begin
                o_done = cyc;
                o_rxd = rxd;
                return;
            end
        end
        $display("FAIL xfer_timeout no DONE within 3000 cycles, cycles=%0d", cyc);
        errors++;
        checks++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
        checks++; if (nss !== 2'b11) begin errors++; $display("FAIL reset_nss got %b want 11", nss); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (rxd !== 8'h00) begin errors++; $display("FAIL reset_rxd got %h want 00", rxd); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [7:0] e;
        exp_q.push_back(model_rx(8'h3C, 8'hC3, 2'b01, 1'b0));
        xfer(8'hA5, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 8'h3C, 8'hC3, 1'b0, 0, 1'b0);
        checks++; if (o_busy1 !== 1'b1) begin errors++; $display("FAIL m0_busy_c1 got %b want 1", o_busy1); end
        checks++; if (o_nss1 !== 2'b10) begin errors++; $display("FAIL m0_nss_c1 got %b want 10", o_nss1); end
        checks++; if (o_first != 2) begin errors++; $display("FAIL m0_first_edge got %0d want 2", o_first); end
        checks++; if (o_mosi !== 8'hA5) begin errors++; $display("FAIL m0_mosi got %h want a5", o_mosi); end
        checks++; if (o_rises != 8) begin errors++; $display("FAIL m0_rises got %0d want 8", o_rises); end
        checks++; if (o_done != 19) begin errors++; $display("FAIL m0_done_cycle got %0d want 19", o_done); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (o_rxd !== e) begin errors++; $display("FAIL m0_rxd got %h want %h", o_rxd, e); end
        last_rxd = e;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_after got %b want 0", busy); end
        checks++; if (nss !== 2'b11) begin errors++; $display("FAIL m0_nss_after got %b want 11", nss); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL m0_done_width got %b want 0", done); end
    endtask

    task automatic test_mode3();
        logic [7:0] e;
        exp_q.push_back(model_rx(8'h5A, 8'hFF, 2'b10, 1'b0));
        xfer(8'h81, 2'b10, 1'b1, 1'b1, 4'd3, 1'b0, 8'h5A, 8'hFF, 1'b0, 0, 1'b0);
        checks++; if (o_nss1 !== 2'b01) begin errors++; $display("FAIL m3_nss_c1 got %b want 01", o_nss1); end
        checks++; if (o_first != 5) begin errors++; $display("FAIL m3_first_edge got %0d want 5", o_first); end
        checks++; if (o_hp != 4) begin errors++; $display("FAIL m3_half_period got %0d want 4", o_hp); end
        checks++; if (o_mosi !== 8'h81) begin errors++; $display("FAIL m3_mosi got %h want 81", o_mosi); end
        checks++; if (o_done != 73) begin errors++; $display("FAIL m3_done_cycle got %0d want 73", o_done); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (o_rxd !== e) begin errors++; $display("FAIL m3_rxd got %h want %h", o_rxd, e); end
        last_rxd = e;
        @(negedge clk);
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL m3_sck_idle got %b want 1", sck); end
        checks++; if (nss !== 2'b11) begin errors++; $display("FAIL m3_nss_after got %b want 11", nss); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, t;
        logic [1:0] want;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            t = 8'h12 + 8'(i * 8'h22);
            exp_q.push_back(model_rx(~t, 8'h00, 2'b01, 1'b0));
            xfer(t, 2'b01, 1'b0, 1'b0, 4'd0, (i < 2), ~t, 8'h00, 1'b0, 0, 1'b0);
            checks++; if (o_nss_or[0] !== 1'b0) begin errors++; $display("FAIL b2b_nss0_held[%0d] got %b want 0", i, o_nss_or[0]); end
            checks++; if (o_done != 19) begin errors++; $display("FAIL b2b_done_cycle[%0d] got %0d want 19", i, o_done); end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++; if (o_rxd !== e) begin errors++; $display("FAIL b2b_rxd[%0d] got %h want %h", i, o_rxd, e); end
            last_rxd = e;
            @(negedge clk);
            want = (i < 2) ? 2'b10 : 2'b11;
            checks++; if (nss !== want) begin errors++; $display("FAIL b2b_nss_after[%0d] got %b want %b", i, nss, want); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after[%0d] got %b want 0", i, busy); end
        end
        exp_q.push_back(model_rx(8'h99, 8'h00, 2'b01, 1'b0));
        xfer(8'h66, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1, 8'h99, 8'h00, 1'b0, 0, 1'b0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (o_rxd !== e) begin errors++; $display("FAIL hold_rxd got %h want %h", o_rxd, e); end
        last_rxd = e;
        @(negedge clk);
        checks++; if (nss !== 2'b10) begin errors++; $display("FAIL hold_idle_nss got %b want 10", nss); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (nss !== 2'b11) begin errors++; $display("FAIL idle_abort_release got %b want 11", nss); end
    endtask

    task automatic test_abort();
        int seen;
        xfer(8'hF0, 2'b11, 1'b1, 1'b0, 4'd1, 1'b0, 8'h0F, 8'h00, 1'b0, 3, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (nss !== 2'b11) begin errors++; $display("FAIL abort_nss got %b want 11", nss); end
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL abort_sck got %b want 1", sck); end
        checks++; if (rxd !== last_rxd) begin errors++; $display("FAIL abort_rxd got %h want %h", rxd, last_rxd); end
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
        txd = 8'h55; mask = 2'b01; cpol = 1'b0; cpha = 1'b0; div = 4'd0; hold = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy !== 1'b0 || nss !== 2'b11) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL start_abort_ignored got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_ignored_start_and_reset();
        logic [7:0] e;
        exp_q.push_back(model_rx(8'hA5, 8'h00, 2'b01, 1'b0));
        xfer(8'h3C, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 1'b1);
        checks++; if (o_mosi !== 8'h3C) begin errors++; $display("FAIL busy_start_mosi got %h want 3c", o_mosi); end
        checks++; if (o_done != 19) begin errors++; $display("FAIL busy_start_done got %0d want 19", o_done); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (o_rxd !== e) begin errors++; $display("FAIL busy_start_rxd got %h want %h", o_rxd, e); end
        last_rxd = e;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_not_queued got %b want 0", busy); end
        txd = 8'hFF; mask = 2'b11; cpol = 1'b1; cpha = 1'b0; div = 4'd2; hold = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (nss !== 2'b11) begin errors++; $display("FAIL rst_nss got %b want 11", nss); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL rst_sck got %b want 0", sck); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", mosi); end
        checks++; if (rxd !== 8'h00) begin errors++; $display("FAIL rst_rxd got %h want 00", rxd); end
        @(negedge clk);
        rst = 1'b0;
        last_rxd = 8'h00;
        @(negedge clk);
    endtask

`ifdef SPI_LSBFIRST_EN
    task automatic test_lsbfirst();
        logic [7:0] e;
        exp_q.push_back(model_rx(8'h80, 8'h00, 2'b01, 1'b1));
        xfer(8'h01, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 8'h80, 8'h00, 1'b1, 0, 1'b0);
        checks++; if (o_first_bit !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got %b want 1", o_first_bit); end
        checks++; if (o_mosi !== rev8(8'h01)) begin errors++; $display("FAIL lsb_mosi got %h want %h", o_mosi, rev8(8'h01)); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (o_rxd !== e) begin errors++; $display("FAIL lsb_rxd got %h want %h", o_rxd, e); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_abort();
        test_ignored_start_and_reset();
`ifdef SPI_LSBFIRST_EN
        test_lsbfirst();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_engine.md
# spi_engine

Hardware SPI shifter for the Gigatron extension CPLD; it replaces bit-banged SCK/MOSI toggling through ctrl codes with a byte-level master. The host logic loads a word and a device mask, and the block then generates SCK, MOSI and the per-device nSS lines. It shifts in MISO from the selected devices and flags completion. Word width, divider width and device count are parameters, and SPI mode is selectable per transfer.

## Interface
- WIDTH, 8, bits per transfer (≥2)
- NSS, 2, number of slave-select lines / MISO inputs
- DIVW, 4, width of half-period divider input
- CLK  in  1  sole clock; all state changes on posedge
- RST  in  1  asynchronous, active-high reset
- START  in  1  request transfer; accepted only when BUSY=0
- ABORT  in  1  terminate transfer or release held nSS
- TXD  in  WIDTH  word to send, latched on accepted START
- SSMASK  in  NSS  nSS lines to assert (1=select); latched on START
- CPOL, CPHA  in  1 each  SPI mode; latched on START
- DIV  in  DIVW  SCK half-period = DIV+1 CLK cycles; latched on START
- HOLD  in  1  keep nSS asserted after completion; latched on START
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle completion pulse
- RXD  out  WIDTH  last received word
- SCK, MOSI  out  1 each  SPI clock / data out
- nSS  out  NSS  active-low selects
- MISO  in  NSS  per-device data in; effective bit = OR over i of (MISO[i] & latched SSMASK[i])

## Operation
- States: IDLE, SETUP, SHIFT, TAIL, FIN.
- IDLE: SCK = latched CPOL. On START & !ABORT, latch all configuration inputs and go to SETUP; BUSY rises the next cycle.
- SETUP: nSS = ~SSMASK. Lasts one half-period. If CPHA=0, MOSI presents the first bit.
- SHIFT: 2*WIDTH half-periods. SCK toggles at the end of each half-period.
- CPHA=0: sample MISO on odd (leading) edges; advance MOSI on even (trailing) edges.
- CPHA=1: advance MOSI on leading edges; sample on trailing edges.
- Bit order is MSB first unless the macro below selects otherwise.
- TAIL: one half-period with SCK = CPOL. Then go to FIN.
- FIN: one cycle. DONE=1, RXD takes the shifted word, BUSY falls next cycle, state returns to IDLE.
- At FIN, nSS returns to all-1 unless HOLD was latched; with HOLD, nSS stays at the mask value in IDLE.
- The half-period counter reloads DIV on every state entry and at each tick. A tick occurs when the counter equals 0.
- ABORT in any state: next cycle returns to IDLE, nSS all-1, SCK=CPOL, no DONE, RXD unchanged. ABORT in IDLE releases held nSS.
- START while BUSY is ignored. START and ABORT in the same cycle: ABORT wins, the transfer is not started.
- SSMASK=0: the transfer runs normally, no nSS asserts, and RXD reads all-0.
- SSMASK with several bits set: all selected lines assert, and MISO is wired-OR.
- Input changes after START have no effect until the next accepted START.

## Timing
- Reset values: SCK=0, MOSI=0, nSS all-1, BUSY=0, DONE=0, RXD=0, state IDLE, latched CPOL=0.
- Let cycle 0 be the cycle START is sampled.
- Cycle 1: BUSY=1 and nSS asserted.
- First SCK edge: cycle 1+(DIV+1).
- DONE: at cycle 1+(2*WIDTH+2)*(DIV+1).
- BUSY=0 from the cycle after DONE. A new START is accepted in that cycle.
- Back-to-back rate: one word per (2*WIDTH+2)*(DIV+1)+2 cycles.
- MISO is sampled by CLK at the edge where SCK toggles; setup is relative to CLK only.
- All outputs are registered; no combinational path from input to output.

## Configuration
- SPI_LSBFIRST_EN defined: adds input port LSBF (1 bit, latched on START). LSBF=1 shifts TXD[0] first and fills RXD from bit 0 upward. LSBF=0 behaves as MSB-first.
- SPI_LSBFIRST_EN undefined: no LSBF port; always MSB first.

## Test plan
- Mode 0 basic: WIDTH=8, DIV=0, SSMASK=01, TXD=A5, MISO[0] echoes 3C. Required: MOSI bits 1,0,1,0,0,1,0,1; 8 rising SCK edges; DONE at cycle 19; RXD=3C; nSS=11 after DONE.
- Mode 3 with divider: CPOL=1, CPHA=1, DIV=3, TXD=81, MISO[1]=1 constant, SSMASK=10. Required: SCK idles 1; half-period 4 cycles; DONE at cycle 73; RXD=FF; MISO[0] ignored.
- HOLD chaining: two transfers with HOLD=1, then one with HOLD=0, SSMASK=01. Required: nSS[0] stays 0 across all three; returns to 1 only after the third DONE. Then ABORT in IDLE with HOLD active releases nSS.
- Abort mid-shift: ABORT after 3 SCK edges. Required: next cycle BUSY=0, nSS=11, SCK=CPOL, no DONE, RXD keeps previous value. START+ABORT in the same cycle starts nothing.
- Ignored START and reset: START during BUSY with different TXD does not change the output stream. RST asserted mid-transfer immediately forces all reset values.
- Macro build: with SPI_LSBFIRST_EN, LSBF=1, TXD=01, MISO pattern 1,0,0,0,0,0,0,0. Required: MOSI emits a 1 first; RXD=01.
